// File: rtl/ring_counter_n.sv
// Parametrised one-hot ring counter with bidirectional 0-3 step advance,
// direct load, binary position and wrap pulse; RING_ONEHOT_CHECK_EN adds Err_s1.
module ring_counter_n #(
    parameter int WIDTH     = 8,
    parameter int RESET_POS = 0,
    parameter int POSW      = $clog2(WIDTH)
) (
    input  logic             Phi1,
    input  logic             Reset_s1,
    input  logic             Enable_s1,
    input  logic             Dir_s1,
    input  logic [1:0]       Step_s1,
    input  logic             Load_s1,
    input  logic [POSW-1:0]  LoadPos_s1,
    output logic [WIDTH-1:0] state_s1,
    output logic [POSW-1:0]  Pos_s1,
    output logic             Wrap_s1
`ifdef RING_ONEHOT_CHECK_EN
    ,
    output logic             Err_s1
`endif
);

    localparam logic [POSW:0]    W_EXT   = (POSW+1)'(WIDTH);
    localparam logic [POSW-1:0]  RST_POS = POSW'(RESET_POS);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [POSW-1:0] r_pos;
    logic            r_wrap;

    logic [POSW:0]   w_pos_ext;
    logic [POSW:0]   w_step_ext;
    logic [POSW:0]   w_load_ext;
    logic [POSW:0]   w_sum;
    logic            w_load_ok;
    logic            w_adv_wrap;
    logic [POSW-1:0] w_pos_nxt;
    logic            w_wrap_nxt;
    logic            w_bad;

    // Modular advance on POSW+1 bits so non-power-of-2 rings wrap correctly
    always_comb begin
        w_pos_ext  = {1'b0, r_pos};
        w_step_ext = {{(POSW-1){1'b0}}, Step_s1};
        w_load_ext = {1'b0, LoadPos_s1};
        w_load_ok  = (w_load_ext < W_EXT);
        w_adv_wrap = 1'b0;
        w_sum      = '0;
        if (!Dir_s1) begin
            w_sum = w_pos_ext + w_step_ext;
            if (w_sum >= W_EXT) begin
                w_sum      = w_sum - W_EXT;
                w_adv_wrap = 1'b1;
            end
        end else if (w_pos_ext < w_step_ext) begin
            w_sum      = w_pos_ext + W_EXT - w_step_ext;
            w_adv_wrap = 1'b1;
        end else begin
            w_sum = w_pos_ext - w_step_ext;
        end
    end

    always_comb begin
        w_pos_nxt  = r_pos;
        w_wrap_nxt = 1'b0;
        if (w_bad) begin
            w_pos_nxt = RST_POS;
        end else if (Load_s1) begin
            if (w_load_ok) begin
                w_pos_nxt = LoadPos_s1;
            end
        end else if (Enable_s1) begin
            w_pos_nxt  = POSW'(w_sum);
            w_wrap_nxt = w_adv_wrap;
        end
    end

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            r_pos  <= RST_POS;
            r_wrap <= 1'b0;
        end else begin
            r_pos  <= w_pos_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

`ifdef RING_ONEHOT_CHECK_EN
    logic [WIDTH-1:0] r_state;
    logic             r_err;

    // Separate state register so upsets in the select lines are detectable
    assign w_bad = (r_state == '0) || ((r_state & (r_state - ONE)) != '0);

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            r_state <= ONE << RST_POS;
            r_err   <= 1'b0;
        end else begin
            r_state <= ONE << w_pos_nxt;
            if (w_bad || (Load_s1 && !w_load_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign state_s1 = r_state;
    assign Err_s1   = r_err;
`else
    assign w_bad    = 1'b0;
    assign state_s1 = ONE << r_pos;
`endif

    assign Pos_s1  = r_pos;
    assign Wrap_s1 = r_wrap;

endmodule

// File: tb/tb_ring_counter_n.sv
// Randomised self-checking bench for ring_counter_n (WIDTH=8 and WIDTH=9
// instances) against an integer modular-arithmetic reference model.
module tb_ring_counter_n;

    logic       Phi1 = 1'b0;
    logic       rst, en, dir, ld;
    logic [1:0] st;
    logic [2:0] lp8;
    logic [3:0] lp9;

    logic [7:0] s8;
    logic [2:0] p8;
    logic       w8;
    logic [8:0] s9;
    logic [3:0] p9;
    logic       w9;
`ifdef RING_ONEHOT_CHECK_EN
    logic       e8, e9;
`endif

    int m8, m9;
    bit mw8, mw9;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 Phi1 = ~Phi1;

    ring_counter_n #(.WIDTH(8), .RESET_POS(0)) u8 (
        .Phi1(Phi1), .Reset_s1(rst), .Enable_s1(en), .Dir_s1(dir),
        .Step_s1(st), .Load_s1(ld), .LoadPos_s1(lp8),
        .state_s1(s8), .Pos_s1(p8), .Wrap_s1(w8)
`ifdef RING_ONEHOT_CHECK_EN
        , .Err_s1(e8)
`endif
    );

    ring_counter_n #(.WIDTH(9), .RESET_POS(3)) u9 (
        .Phi1(Phi1), .Reset_s1(rst), .Enable_s1(en), .Dir_s1(dir),
        .Step_s1(st), .Load_s1(ld), .LoadPos_s1(lp9),
        .state_s1(s9), .Pos_s1(p9), .Wrap_s1(w9)
`ifdef RING_ONEHOT_CHECK_EN
        , .Err_s1(e9)
`endif
    );

    function automatic int nxt(input int w, input int rp, input int pos,
                               input bit r, input bit l, input int lpos,
                               input bit e, input bit d, input int s,
                               output bit wr);
        wr = 1'b0;
        if (r) return rp;
        if (l) return (lpos < w) ? lpos : pos;
        if (!e) return pos;
        if (!d) begin
            wr = (pos + s) >= w;
            return (pos + s) % w;
        end
        wr = pos < s;
        return (pos - s + w) % w;
    endfunction

    task automatic drive(input bit r, input bit l, input bit e, input bit d,
                         input int s, input int l8, input int l9);
        @(negedge Phi1);
        rst = r; ld = l; en = e; dir = d;
        st  = 2'(s); lp8 = 3'(l8); lp9 = 4'(l9);
    endtask

    task automatic tick();
        @(posedge Phi1);
        m8 = nxt(8, 0, m8, rst, ld, int'(lp8), en, dir, int'(st), mw8);
        m9 = nxt(9, 3, m9, rst, ld, int'(lp9), en, dir, int'(st), mw9);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 3, 5, 5);
        tick();
        n_chk++;
        if ({s8, p8, w8} !== {8'h01, 3'd0, 1'b0}) begin
            $display("FAIL reset8: got s=%h p=%0d w=%b exp s=01 p=0 w=0", s8, p8, w8);
        end else n_pass++;
        n_chk++;
        if ({s9, p9, w9} !== {9'h008, 4'd3, 1'b0}) begin
            $display("FAIL reset9: got s=%h p=%0d w=%b exp s=008 p=3 w=0", s9, p9, w9);
        end else n_pass++;
    endtask

    task automatic test_walk();
        int wraps = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 1, 0, 0);
            tick();
            if (w8 === 1'b1) wraps++;
            n_chk++;
            if ({s8, p8, w8} !== {8'(1 << m8), 3'(m8), mw8}) begin
                $display("FAIL walk8[%0d]: got s=%h p=%0d w=%b exp s=%h p=%0d w=%b",
                         i, s8, p8, w8, 8'(1 << m8), m8, mw8);
            end else n_pass++;
        end
        n_chk++;
        if (wraps != 1 || s8 !== 8'h01) begin
            $display("FAIL walk8_wrapcount: got wraps=%0d s=%h exp wraps=1 s=01", wraps, s8);
        end else n_pass++;
    endtask

    task automatic test_step3_w9();
        drive(0, 1, 0, 0, 0, 7, 7);
        tick();
        drive(0, 0, 1, 0, 3, 0, 0);
        tick();
        n_chk++;
        if ({s9, p9, w9} !== {9'b000000010, 4'd1, 1'b1}) begin
            $display("FAIL step3_w9: got s=%h p=%0d w=%b exp s=002 p=1 w=1", s9, p9, w9);
        end else n_pass++;
        n_chk++;
        if ({s8, p8, w8} !== {8'(1 << m8), 3'(m8), mw8}) begin
            $display("FAIL step3_w8: got s=%h p=%0d w=%b exp p=%0d w=%b", s8, p8, w8, m8, mw8);
        end else n_pass++;
        drive(0, 0, 1, 0, 2, 0, 0);
        tick();
        n_chk++;
        if ({s9, p9, w9} !== {9'h008, 4'd3, 1'b0}) begin
            $display("FAIL step2_w9: got s=%h p=%0d w=%b exp s=008 p=3 w=0", s9, p9, w9);
        end else n_pass++;
    endtask

    task automatic test_dir_back();
        drive(0, 1, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 1, 1, 2, 0, 0);
        tick();
        n_chk++;
        if ({s8, p8, w8} !== {8'h80, 3'd7, 1'b1}) begin
            $display("FAIL back8: got s=%h p=%0d w=%b exp s=80 p=7 w=1", s8, p8, w8);
        end else n_pass++;
        n_chk++;
        if ({s9, p9, w9} !== {9'h100, 4'd8, 1'b1}) begin
            $display("FAIL back9: got s=%h p=%0d w=%b exp s=100 p=8 w=1", s9, p9, w9);
        end else n_pass++;
        drive(0, 0, 1, 1, 0, 0, 0);
        tick();
        n_chk++;
        if ({s8, p8, w8} !== {8'h80, 3'd7, 1'b0}) begin
            $display("FAIL hold8: got s=%h p=%0d w=%b exp s=80 p=7 w=0", s8, p8, w8);
        end else n_pass++;
    endtask

    task automatic test_load_priority();
        drive(0, 1, 1, 0, 3, 5, 5);
        tick();
        n_chk++;
        if ({s8, p8, w8} !== {8'h20, 3'd5, 1'b0}) begin
            $display("FAIL load8: got s=%h p=%0d w=%b exp s=20 p=5 w=0", s8, p8, w8);
        end else n_pass++;
        drive(1, 1, 1, 0, 3, 6, 6);
        tick();
        n_chk++;
        if ({s8, p8, w8} !== {8'h01, 3'd0, 1'b0}) begin
            $display("FAIL rst_over_load8: got s=%h p=%0d w=%b exp s=01 p=0 w=0", s8, p8, w8);
        end else n_pass++;
    endtask

    task automatic test_oob_load();
        drive(0, 1, 0, 0, 0, 2, 6);
        tick();
        drive(0, 1, 1, 0, 3, 4, 12);
        tick();
        n_chk++;
        if ({s9, p9, w9} !== {9'h040, 4'd6, 1'b0}) begin
            $display("FAIL oob9: got s=%h p=%0d w=%b exp s=040 p=6 w=0", s9, p9, w9);
        end else n_pass++;
        n_chk++;
        if ({s8, p8} !== {8'h10, 3'd4}) begin
            $display("FAIL inrange8: got s=%h p=%0d exp s=10 p=4", s8, p8);
        end else n_pass++;
`ifdef RING_ONEHOT_CHECK_EN
        drive(0, 0, 1, 0, 1, 0, 0);
        tick();
        n_chk++;
        if ({e9, e8} !== 2'b10) begin
            $display("FAIL err_sticky: got e9=%b e8=%b exp e9=1 e8=0", e9, e8);
        end else n_pass++;
`endif
    endtask

`ifdef RING_ONEHOT_CHECK_EN
    task automatic test_onehot();
        drive(0, 1, 0, 0, 0, 3, 3);
        tick();
        @(negedge Phi1);
        force u8.r_state = 8'h24;
        #1 release u8.r_state;
        en = 1'b1; ld = 1'b0; dir = 1'b0; st = 2'd1;
        tick();
        m8 = 0; mw8 = 1'b0;
        n_chk++;
        if ({s8, p8, w8, e8} !== {8'h01, 3'd0, 1'b0, 1'b1}) begin
            $display("FAIL seu8: got s=%h p=%0d w=%b e=%b exp s=01 p=0 w=0 e=1", s8, p8, w8, e8);
        end else n_pass++;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if ({e9, e8} !== 2'b00) begin
            $display("FAIL err_clear: got e9=%b e8=%b exp 00", e9, e8);
        end else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            tick();
            n_chk++;
            if ({s8, p8, w8} !== {8'(1 << m8), 3'(m8), mw8}) begin
                $display("FAIL rand8[%0d]: got s=%h p=%0d w=%b exp s=%h p=%0d w=%b",
                         i, s8, p8, w8, 8'(1 << m8), m8, mw8);
            end else n_pass++;
            n_chk++;
            if ({s9, p9, w9} !== {9'(1 << m9), 4'(m9), mw9}) begin
                $display("FAIL rand9[%0d]: got s=%h p=%0d w=%b exp s=%h p=%0d w=%b",
                         i, s9, p9, w9, 9'(1 << m9), m9, mw9);
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0;
        st = 2'd0; lp8 = '0; lp9 = '0;
        m8 = 0; m9 = 3; mw8 = 1'b0; mw9 = 1'b0;
        test_reset();
        test_walk();
        test_step3_w9();
        test_dir_back();
        test_load_priority();
        test_oob_load();
`ifdef RING_ONEHOT_CHECK_EN
        test_onehot();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
